// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue.
// Sends one word-address request per cycle to a synchronous instruction
// memory. Returned words are buffered, each with its PC+4, in a DEPTH-entry
// FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect
// from EX flushes the FIFO, drops the response that is in flight, and
// restarts fetch at the new target.
module if_prefetch_queue #(
    parameter int             DEPTH       = 4,
    parameter int             AW          = 30,
    parameter logic [AW-1:0]  RESET_WADDR = '0
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    output logic                         IREQ,
    output logic [AW-1:0]                IADDR,
    input  logic [31:0]                  INSTR,
    input  logic                         REDIRECT,
    input  logic [31:0]                  REDIRECT_PC,
    output logic                         DVALID,
    input  logic                         DREADY,
    output logic [31:0]                  DINSTR,
    output logic [31:0]                  DPC4,
    output logic [$clog2(DEPTH+1)-1:0]   QCOUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Fetch and queue state
    logic [AW-1:0] fpc_reg;
    logic [AW-1:0] infl_addr_reg;
    logic          infl_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Queue storage (no reset; only entries below count_reg are ever observed)
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];

    logic          not_empty;
    logic          pop;
    logic          push;
    logic          ireq;
    logic [CW:0]   occ_after;
    logic [AW-1:0] push_next_waddr;
    logic [AW+1:0] push_pc4_wide;
    logic [31:0]   push_pc4;

    assign not_empty = (count_reg != '0);

    // A redirect overrides the handshake. A squashed instruction must not retire.
    assign pop  = not_empty & DREADY & ~REDIRECT;

    // The response to last cycle's request arrives now. It is discarded on a redirect.
    assign push = infl_reg & ~REDIRECT;

    // Count slots already claimed after this cycle's pop. A new request is
    // allowed only when its response is guaranteed a free slot.
    assign occ_after = {1'b0, count_reg} + (CW+1)'(infl_reg) - (CW+1)'(pop);
    assign ireq      = RSTN & ~REDIRECT & (occ_after < (CW+1)'(DEPTH));

    // PC+4 of the returning word, as a zero-extended byte address
    assign push_next_waddr = infl_addr_reg + AW'(1);
    assign push_pc4_wide   = {push_next_waddr, 2'b00};
    assign push_pc4        = 32'(push_pc4_wide);

    assign IREQ   = ireq;
    assign IADDR  = fpc_reg;
    assign DVALID = not_empty;
    assign DINSTR = not_empty ? instr_mem[rd_ptr_reg] : 32'h0;
    assign DPC4   = not_empty ? pc4_mem[rd_ptr_reg]   : 32'h0;
    assign QCOUNT = count_reg;

    // Fetch PC, in-flight tracking and FIFO bookkeeping; redirect flushes everything
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fpc_reg       <= RESET_WADDR;
            infl_addr_reg <= '0;
            infl_reg      <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
        end else if (REDIRECT) begin
            fpc_reg    <= REDIRECT_PC[AW+1:2];
            infl_reg   <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (ireq) begin
                fpc_reg       <= fpc_reg + AW'(1);
                infl_addr_reg <= fpc_reg;
                infl_reg      <= 1'b1;
            end else begin
                infl_reg      <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Write the returning word and its PC+4 into the slot at the write pointer
    always_ff @(posedge CLK) begin
        if (RSTN && push) begin
            instr_mem[wr_ptr_reg] <= INSTR;
            pc4_mem[wr_ptr_reg]   <= push_pc4;
        end
    end

    // The request throttle must never let a push land on a full queue, or a pop on an empty one
    overflow_chk: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && !pop && count_reg == CW'(DEPTH)));
    underflow_chk: assert property (@(posedge CLK) disable iff (!RSTN)
        !(pop && count_reg == '0));

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-register PC/FD path of the 5-stage core. Issues word-address requests to the synchronous instruction memory, buffers returned instructions with their PC+4 in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake. Handles branch/jump redirects by flushing the queue and dropping stale in-flight responses.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
AW, 30, instruction word-address width
RESET_WADDR, 0, word address fetched first after reset

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTN  input  1  asynchronous active-low reset
IREQ  output  1  instruction memory request (combinational from state)
IADDR  output  AW  word address of the request
INSTR  input  32  memory read data, valid in the cycle after IREQ
REDIRECT  input  1  EX-stage taken branch/jump, flush request
REDIRECT_PC  input  32  byte target; bits [1:0] and bits above AW+1 ignored
DVALID  output  1  queue head valid
DREADY  input  1  decode accepts head
DINSTR  output  32  head instruction; 0 when empty
DPC4  output  32  head PC+4 byte address; 0 when empty
QCOUNT  output  clog2(DEPTH+1)  occupied entries

Behaviour:
- State: fpc (AW bits), FIFO rd/wr pointers + count, infl flag, infl_addr (AW).
- Async reset: fpc=RESET_WADDR, count=0, pointers=0, infl=0. While RSTN low: IREQ=0, DVALID=0, DINSTR=0, DPC4=0, QCOUNT=0, IADDR=RESET_WADDR.
- pop = DVALID & DREADY & !REDIRECT.
- IREQ = !REDIRECT & (count + infl - pop < DEPTH). IADDR = fpc.
- On IREQ: fpc <= fpc+1 (mod 2^AW); infl <= 1; infl_addr <= fpc. Else infl <= 0.
- Response: if infl & !REDIRECT, push {INSTR, PC4} where PC4 = zero-extended (((infl_addr+1) mod 2^AW) << 2).
- Simultaneous push and pop: count unchanged, both pointers advance. Push never occurs when full (guaranteed by the IREQ rule). Assert flags overflow and underflow as errors in simulation.
- DVALID = (count != 0). Head outputs come from registered FIFO storage; there is no memory-to-decode bypass.
- Latency: IREQ in cycle t gives data in t+1, captured at the end of t+1, DVALID in t+2. Sustained throughput is 1 instr/cycle when DREADY=1 and DEPTH >= 2.
- Stall: DREADY=0 holds the head. Requests continue until count+infl = DEPTH, then IREQ=0. Order is preserved and nothing is lost or duplicated.
- REDIRECT cycle: IREQ=0; the response arriving this cycle is discarded; pop suppressed. At the edge: count=0, pointers=0, infl=0, fpc=REDIRECT_PC[AW+1:2]. The first new IREQ is in the next cycle, and the first new DVALID comes 3 cycles after the redirect cycle.
- Back-to-back REDIRECTs: the last one wins; nothing is fetched between them.
- Reset asserted mid-operation: all state cleared immediately and asynchronously. No response is pushed on the first edge after release.

Test Plan:
- Reset release, DREADY=1, memory returns 0xA000_0000|addr -> IADDR 0,1,2,... every cycle from cycle 0; DVALID first in cycle 2 with DINSTR=0xA000_0000, DPC4=0x4; then 0xA000_0001/0x8, etc., one per cycle, QCOUNT <= 1.
- DREADY=0 from cycle 2 -> IREQ drops after IADDR 3, QCOUNT reaches 4 and holds, no fifth request. Raise DREADY -> DINSTR 0..3 then 4.. in order with no gap beyond 1 cycle and no duplicates.
- REDIRECT=1, REDIRECT_PC=0x0000_0100 while the queue holds 2 entries and one is in flight -> IREQ=0 that cycle, QCOUNT=0 next cycle, next IADDR=0x40, DVALID low for 2 cycles, then DINSTR=0xA000_0040, DPC4=0x104. The stale in-flight word never appears.
- Full queue, DREADY=1 and REDIRECT=1 in the same cycle, REDIRECT_PC=0x203 -> no pop; queue cleared; fetch resumes at IADDR 0x80.
- AW=4, RESET_WADDR=14 -> IADDR 14,15,0,1; DPC4 0x3C, 0x00, 0x04, 0x08.
- RSTN pulsed low mid-stream with a full queue -> DVALID, IREQ and QCOUNT go to 0 before the next edge. After release, fetch restarts at RESET_WADDR and the pre-reset in-flight data is not pushed.
